// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder with carry-in.
// One bit per clock, LSB first; registered sum/cout/ovf with a done pulse.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [WIDTH-2:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_next;

    assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
    assign w_co   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    // New sum bit enters at the top; after the last bit this is the result.
    assign w_next = {w_s, r_sh};

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign busy = r_busy;
    assign done = r_done;

    // Control FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= cin;
                        r_sh    <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_ADD: begin
                    r_sh  <= w_next[WIDTH-1:1];
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_c   <= w_co;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // r_c here is the carry into the MSB.
                        r_sum   <= w_next;
                        r_cout  <= w_co;
                        r_ovf   <= r_c ^ w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, corner sequences and random ops
// checked against an integer-arithmetic reference model.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: unsigned and signed integer sums, no bit-level logic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic c);
        int u;
        int sx;
        int sy;
        int s;
        logic [W:0] uv;
        logic ov;
        u  = int'(x) + int'(y) + int'(c);
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        s  = sx + sy + int'(c);
        ov = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
        uv = u[W:0];
        return {ov, uv};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one op; scramble operands during ADD; return at done cycle.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xc, output int lat, output int nbusy);
        start = 1'b1;
        a     = xa;
        b     = xb;
        cin   = xc;
        tick();
        start = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            tick();
            lat++;
        end
    endtask

    task automatic run_chk(input string nm, input logic [W-1:0] xa,
                           input logic [W-1:0] xb, input logic xc);
        int lat;
        int nb;
        logic [W+1:0] e;
        e = model(xa, xb, xc);
        do_op(xa, xb, xc, lat, nb);
        chk({nm, "_lat"}, lat, W);
        chk({nm, "_sum"}, sum, e[W-1:0]);
        chk({nm, "_cout"}, cout, e[W]);
        chk({nm, "_ovf"}, ovf, e[W+1]);
    endtask

    initial begin
        vec_t tbl[7];
        int lat;
        int nb;
        int nd;
        logic [W-1:0] opa[7];
        logic [W-1:0] opb[7];
        logic         opc[7];
        logic [W+1:0] e;
        logic [W-1:0] prev;

        tbl[0] = '{4'b1010, 4'b0011, 1'b0, 4'b1101, 1'b0, 1'b0};
        tbl[1] = '{4'b1100, 4'b1001, 1'b0, 4'b0101, 1'b1, 1'b1};
        tbl[2] = '{4'b0111, 4'b0001, 1'b1, 4'b1001, 1'b0, 1'b1};
        tbl[3] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[4] = '{4'b0100, 4'b0100, 1'b0, 4'b1000, 1'b0, 1'b1};
        tbl[5] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[6] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b1;
        a     = 4'hF;
        b     = 4'hF;
        cin   = 1'b1;
        repeat (3) tick();
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        start = 1'b0;
        rst   = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].c, lat, nb);
            chk($sformatf("vec%0d_lat", i), lat, W);
            chk($sformatf("vec%0d_busy", i), nb, W);
            chk($sformatf("vec%0d_sum", i), sum, tbl[i].s);
            chk($sformatf("vec%0d_cout", i), cout, tbl[i].co);
            chk($sformatf("vec%0d_ovf", i), ovf, tbl[i].ov);
            tick();
            chk($sformatf("vec%0d_pulse", i), done, 0);
            chk($sformatf("vec%0d_hold", i), sum, tbl[i].s);
        end

        // Start while busy is ignored: one done, busy 4 cycles.
        start = 1'b1;
        a     = 4'b1010;
        b     = 4'b0011;
        cin   = 1'b0;
        tick();
        start = 1'b0;
        nb    = 0;
        nd    = 0;
        for (int c = 0; c < 14; c++) begin
            start = (c == 1 || c == 2);
            a     = 4'b0001;
            b     = 4'b0001;
            if (busy) nb++;
            if (done) begin
                nd++;
                chk("ign_sum", sum, 4'b1101);
                chk("ign_cout", cout, 0);
            end
            tick();
        end
        chk("ign_busy_cycles", nb, W);
        chk("ign_done_pulses", nd, 1);
        chk("ign_sum_after", sum, 4'b1101);

        // Reset during ADD aborts the op.
        start = 1'b1;
        a     = 4'b0100;
        b     = 4'b0100;
        cin   = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_ovf", ovf, 0);
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            if (done || busy) nd++;
            tick();
        end
        chk("abort_idle", nd, 0);
        run_chk("after_abort", 4'b0100, 4'b0100, 1'b0);

        // Reset in the DONE cycle hides the following cycle.
        tick();
        do_op(4'b0011, 4'b0101, 1'b0, lat, nb);
        chk("rstdone_seen", done, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstdone_done", done, 0);
        chk("rstdone_sum", sum, 0);

        // Back-to-back ops with start held high.
        for (int k = 0; k < 7; k++) begin
            opa[k] = W'($urandom);
            opb[k] = W'($urandom);
            opc[k] = 1'($urandom);
        end
        start = 1'b1;
        a     = opa[0];
        b     = opb[0];
        cin   = opc[0];
        tick();
        prev  = sum;
        for (int k = 0; k < 6; k++) begin
            lat = 0;
            chk($sformatf("b2b%0d_busy", k), busy, 1);
            chk($sformatf("b2b%0d_hold", k), sum, prev);
            while (!done && lat < 20) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
                tick();
                lat++;
            end
            e = model(opa[k], opb[k], opc[k]);
            chk($sformatf("b2b%0d_lat", k), lat, W);
            chk($sformatf("b2b%0d_sum", k), sum, e[W-1:0]);
            chk($sformatf("b2b%0d_cout", k), cout, e[W]);
            chk($sformatf("b2b%0d_ovf", k), ovf, e[W+1]);
            prev  = sum;
            a     = opa[k+1];
            b     = opb[k+1];
            cin   = opc[k+1];
            start = (k < 5);
            tick();
        end
        start = 1'b0;
        chk("b2b_end_busy", busy, 0);
        tick();

        // Random ops with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            run_chk($sformatf("rnd%0d", i), W'($urandom), W'($urandom),
                    1'($urandom));
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
